game_status_ctrl_module: RTL



---
 rtl/game_pkg.sv | 12 +
 rtl/game_status_ctrl_module_flash_timer.sv | 50 +++++
 rtl/game_status_ctrl_module.sv | 74 +++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared one-hot game status encoding for the snake game
package game_pkg;

    localparam int GS_W = 3;

    typedef enum logic [GS_W-1:0] {
        GS_START = 3'b001,
        GS_PLAY  = 3'b010,
        GS_END   = 3'b100
    } game_status_t;

endpackage

// File: rtl/game_status_ctrl_module_flash_timer.sv
// rtl/game_status_ctrl_module_flash_timer.sv - END-screen flash prescaler and toggle counter
module flash_timer_module #(
    parameter int FLASH_HALF_CYC = 20_000_000,
    parameter int FLASH_TIMES    = 4
) (
    input  logic CLK_40M,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic flash_on,
    output logic done
);

    localparam int CW = $clog2(FLASH_HALF_CYC);
    localparam int TW = $clog2(2 * FLASH_TIMES + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(FLASH_HALF_CYC - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * FLASH_TIMES - 1);

    logic [CW-1:0] cyc_cnt;
    logic [TW-1:0] tog_cnt;

    // clear restarts the sequence; enable at clear time arms the first visible half-period
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            cyc_cnt  <= '0;
            tog_cnt  <= '0;
            flash_on <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            cyc_cnt  <= '0;
            tog_cnt  <= '0;
            flash_on <= enable;
            done     <= 1'b0;
        end else if (enable && !done) begin
            if (cyc_cnt == CYC_LAST) begin
                cyc_cnt <= '0;
                tog_cnt <= tog_cnt + 1'b1;
                if (tog_cnt == TOG_LAST) begin
                    done     <= 1'b1;
                    flash_on <= 1'b0;
                end else begin
                    flash_on <= ~flash_on;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_status_ctrl_module.sv
// rtl/game_status_ctrl_module.sv - START/PLAY/END game flow FSM with END-screen flash timing
module game_status_ctrl_module
    import game_pkg::*;
#(
    parameter int FLASH_HALF_CYC = 20_000_000,
    parameter int FLASH_TIMES    = 4
) (
    input  logic            CLK_40M,
    input  logic            RST,
    input  logic            start_key_pulse,
    input  logic            hit_wall_sig,
    input  logic            hit_body_sig,
    output logic [GS_W-1:0] Game_status,
    output logic            Flash_over_sig,
    output logic            flash_on,
    output logic            game_init_pulse
);

    game_status_t state;
    logic         hit;
    logic         enter_end;
    logic         leave_end;
    logic         timer_clear;
    logic         timer_enable;
    logic         flash_done;

    assign hit       = hit_wall_sig | hit_body_sig;
    assign enter_end = (state == GS_PLAY) && hit;
    assign leave_end = (state == GS_END) && flash_done && start_key_pulse;

    // Timer is held cleared everywhere except inside END, so its outputs read 0 outside END
    assign timer_clear  = (state != GS_END) || leave_end;
    assign timer_enable = enter_end || ((state == GS_END) && !leave_end);

    flash_timer_module #(
        .FLASH_HALF_CYC(FLASH_HALF_CYC),
        .FLASH_TIMES   (FLASH_TIMES)
    ) u_flash_timer (
        .CLK_40M (CLK_40M),
        .RST     (RST),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .flash_on(flash_on),
        .done    (flash_done)
    );

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state           <= GS_START;
            game_init_pulse <= 1'b0;
        end else begin
            game_init_pulse <= 1'b0;
            case (state)
                GS_START: begin
                    if (start_key_pulse) begin
                        state           <= GS_PLAY;
                        game_init_pulse <= 1'b1;
                    end
                end
                GS_PLAY: begin
                    if (hit) state <= GS_END;
                end
                GS_END: begin
                    if (flash_done && start_key_pulse) state <= GS_START;
                end
                default: state <= GS_START;
            endcase
        end
    end

    assign Game_status    = state;
    assign Flash_over_sig = flash_done;

endmodule
